// File: rtl/wishbone_nn_stream_bridge.sv
// Wishbone slave feeding an NN core through an input FIFO and collecting class IDs in an output FIFO.
// Optional interrupt output is built when the macro WB_NN_IRQ_EN is defined.

module wishbone_nn_stream_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // Full/empty come from the pre-edge count, so a push on a full FIFO is refused even with a pop.
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module wishbone_nn_stream_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IN_WIDTH  = 32,
  parameter int          OUT_WIDTH = 8,
  parameter int          IN_DEPTH  = 8,
  parameter int          OUT_DEPTH = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_dat_i,
  input  logic [31:0]          wbs_adr_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [IN_WIDTH-1:0]  nn_in_data,
  output logic                 nn_in_valid,
  input  logic                 nn_in_ready,
  input  logic [OUT_WIDTH-1:0] nn_out_data,
  input  logic                 nn_out_valid,
  output logic                 nn_out_ready
`ifdef WB_NN_IRQ_EN
  ,output logic                irq_o
`endif
);
  localparam logic [31:0] ADR_DATA = BASE_ADDR;
  localparam logic [31:0] ADR_STAT = BASE_ADDR + 32'h4;
  localparam logic [31:0] ADR_CTRL = BASE_ADDR + 32'h8;
  localparam int ICW = $clog2(IN_DEPTH+1);
  localparam int OCW = $clog2(OUT_DEPTH+1);

  logic                 ack_q;
  logic [31:0]          dat_q, rdata_d, status_w;
  logic                 ovf_q, udf_q, irq_bit;
  logic                 sel_data, sel_stat, sel_ctrl, hit;
  logic                 wr_data, rd_data, wr_ctrl, flush, clr_flags;
  logic [ICW-1:0]       in_cnt;
  logic [OCW-1:0]       out_cnt;
  logic                 in_full, in_empty, out_full, out_empty;
  logic [OUT_WIDTH-1:0] out_head;
  logic                 unused_inputs;

  assign unused_inputs = ^{wbs_sel_i, wbs_dat_i};

  assign sel_data  = (wbs_adr_i == ADR_DATA);
  assign sel_stat  = (wbs_adr_i == ADR_STAT);
  assign sel_ctrl  = (wbs_adr_i == ADR_CTRL);
  // Qualifying with !ack_q forces a one-cycle gap between consecutive accesses.
  assign hit       = wbs_stb_i & wbs_cyc_i & (sel_data | sel_stat | sel_ctrl) & ~ack_q;
  assign wr_data   = hit & wbs_we_i & sel_data;
  assign rd_data   = hit & ~wbs_we_i & sel_data;
  assign wr_ctrl   = hit & wbs_we_i & sel_ctrl;
  assign flush     = wr_ctrl & wbs_dat_i[0];
  assign clr_flags = wr_ctrl & wbs_dat_i[1];

  assign nn_in_valid  = ~in_empty;
  assign nn_out_ready = ~out_full;
  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;

  wishbone_nn_stream_bridge_fifo #(.WIDTH(IN_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (flush),
    .push_i  (wr_data),
    .pop_i   (nn_in_valid & nn_in_ready),
    .data_i  (wbs_dat_i[IN_WIDTH-1:0]),
    .data_o  (nn_in_data),
    .count_o (in_cnt),
    .full_o  (in_full),
    .empty_o (in_empty)
  );

  wishbone_nn_stream_bridge_fifo #(.WIDTH(OUT_WIDTH), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (flush),
    .push_i  (nn_out_valid & nn_out_ready),
    .pop_i   (rd_data),
    .data_i  (nn_out_data),
    .data_o  (out_head),
    .count_o (out_cnt),
    .full_o  (out_full),
    .empty_o (out_empty)
  );

  function automatic logic [7:0] sat8(input logic [31:0] v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

  assign status_w = {11'b0, irq_bit, udf_q, ovf_q, out_empty, in_full,
                     sat8(32'(out_cnt)), sat8(32'(in_cnt))};

  always_comb begin
    rdata_d = '0;
    if (sel_data && !out_empty) rdata_d[OUT_WIDTH-1:0] = out_head;
    else if (sel_stat)          rdata_d = status_w;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ack_q <= hit;
      dat_q <= (hit && !wbs_we_i) ? rdata_d : 32'h0;
      if (clr_flags) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (wr_data && in_full)  ovf_q <= 1'b1;
      if (rd_data && out_empty) udf_q <= 1'b1;
    end
  end

`ifdef WB_NN_IRQ_EN
  logic irq_q, mask_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_q  <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      irq_q <= ~mask_q & (~out_empty | ovf_q | udf_q);
      if (wr_ctrl) mask_q <= wbs_dat_i[2];
    end
  end

  assign irq_o   = irq_q;
  assign irq_bit = irq_q;
`else
  assign irq_bit = 1'b0;
`endif
endmodule

// File: tb/tb_wishbone_nn_stream_bridge.sv
// Directed plus randomized bench for wishbone_nn_stream_bridge against a queue-based reference model.
module tb_wishbone_nn_stream_bridge;
  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int IN_DEPTH  = 8;
  localparam int OUT_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] dat_i = '0, adr = '0;
  logic        ack;
  logic [31:0] dat_o;
  logic [31:0] nn_in_data;
  logic        nn_in_valid, nn_in_ready = 1'b0;
  logic [7:0]  nn_out_data = '0;
  logic        nn_out_valid = 1'b0, nn_out_ready;
`ifdef WB_NN_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] in_q[$];
  logic [7:0]  out_q[$];
  bit m_ovf, m_udf, m_mask, exp_ack, exp_irq;

  always #5 clk = ~clk;

  wishbone_nn_stream_bridge dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs_stb_i    (stb),
    .wbs_cyc_i    (cyc),
    .wbs_we_i     (we),
    .wbs_sel_i    (sel),
    .wbs_dat_i    (dat_i),
    .wbs_adr_i    (adr),
    .wbs_ack_o    (ack),
    .wbs_dat_o    (dat_o),
    .nn_in_data   (nn_in_data),
    .nn_in_valid  (nn_in_valid),
    .nn_in_ready  (nn_in_ready),
    .nn_out_data  (nn_out_data),
    .nn_out_valid (nn_out_valid),
    .nn_out_ready (nn_out_ready)
`ifdef WB_NN_IRQ_EN
    ,.irq_o       (irq)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    logic [31:0] s;
    s = '0;
    s[7:0]  = 8'(in_q.size());
    s[15:8] = 8'(out_q.size());
    s[16]   = (in_q.size() == IN_DEPTH);
    s[17]   = (out_q.size() == 0);
    s[18]   = m_ovf;
    s[19]   = m_udf;
`ifdef WB_NN_IRQ_EN
    s[20]   = exp_irq;
`endif
    return s;
  endfunction

  // One clock cycle: drive inputs, advance the model by the same rules, then compare outputs.
  task automatic step(input bit do_wb, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input bit rdy, input bit ov, input logic [7:0] od);
    bit mapped, hit, flush, nirq;
    int in_n, out_n;
    logic [31:0] rd;
    stb = do_wb; cyc = do_wb; we = wr; adr = a; dat_i = wd;
    nn_in_ready = rdy; nn_out_valid = ov; nn_out_data = od;
    mapped = (a == BASE) || (a == BASE + 32'h4) || (a == BASE + 32'h8);
    hit    = do_wb && mapped && !exp_ack;
    in_n   = in_q.size();
    out_n  = out_q.size();
    rd     = '0;
    nirq   = !m_mask && (out_n > 0 || m_ovf || m_udf);
    if (hit && !wr && a == BASE + 32'h4) rd = status_exp();
    flush = hit && wr && a == BASE + 32'h8 && wd[0];
    if (hit && wr && a == BASE + 32'h8) begin
      if (wd[1]) begin m_ovf = 0; m_udf = 0; end
`ifdef WB_NN_IRQ_EN
      m_mask = wd[2];
`endif
    end
    if (flush) begin
      in_q.delete();
      out_q.delete();
    end else begin
      if (rdy && in_n > 0) void'(in_q.pop_front());
      if (hit && wr && a == BASE) begin
        if (in_n < IN_DEPTH) in_q.push_back(wd);
        else m_ovf = 1;
      end
      if (hit && !wr && a == BASE) begin
        if (out_n > 0) rd = {24'h0, out_q.pop_front()};
        else m_udf = 1;
      end
      if (ov && out_n < OUT_DEPTH) out_q.push_back(od);
    end
    @(posedge clk); #1;
    exp_ack = hit;
    exp_irq = nirq;
    check("ack", {31'h0, ack}, {31'h0, hit});
    check("dat_o", dat_o, (hit && !wr) ? rd : 32'h0);
    check("nn_in_valid", {31'h0, nn_in_valid}, {31'h0, in_q.size() > 0});
    if (in_q.size() > 0) check("nn_in_data", nn_in_data, in_q[0]);
    check("nn_out_ready", {31'h0, nn_out_ready}, {31'h0, out_q.size() < OUT_DEPTH});
`ifdef WB_NN_IRQ_EN
    check("irq_o", {31'h0, irq}, {31'h0, exp_irq});
`endif
  endtask

  task automatic idle(input bit rdy = 0);
    step(0, 0, 32'h0, 32'h0, rdy, 0, 8'h0);
  endtask

  task automatic wb_wr(input logic [31:0] a, input logic [31:0] d);
    step(1, 1, a, d, 0, 0, 8'h0);
    idle();
  endtask

  task automatic wb_rd(input logic [31:0] a);
    step(1, 0, a, 32'h0, 0, 0, 8'h0);
    idle();
  endtask

  initial begin
    int op;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_dat_o", dat_o, 32'h0);
    check("rst_in_valid", {31'h0, nn_in_valid}, 32'h0);
    check("rst_out_ready", {31'h0, nn_out_ready}, 32'h1);
    rst = 1'b0;
    idle();
    wb_rd(BASE + 32'h4);

    // Single push becomes visible at the NN head.
    wb_wr(BASE, 32'hA5);
    check("head_A5", nn_in_data, 32'hA5);
    for (int i = 1; i < IN_DEPTH; i++) wb_wr(BASE, 32'h100 + i);
    wb_wr(BASE, 32'hDEAD);
    wb_rd(BASE + 32'h4);
    check("ovf_flag", {31'h0, m_ovf}, 32'h1);
    for (int i = 0; i < IN_DEPTH + 2; i++) idle(1);

    // Results 3 and 7, then an underflowing read.
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h3);
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h7);
    wb_rd(BASE);
    wb_rd(BASE);
    wb_rd(BASE);
    wb_rd(BASE + 32'h4);
    wb_rd(BASE + 32'h8);
    wb_wr(BASE + 32'h8, 32'h2);
    wb_rd(BASE + 32'h4);

    // Half-full input FIFO with simultaneous push and pop.
    for (int i = 0; i < IN_DEPTH / 2; i++) wb_wr(BASE, 32'h200 + i);
    step(1, 1, BASE, 32'h2FF, 1, 0, 8'h0);
    idle();
    wb_rd(BASE + 32'h4);
    for (int i = 0; i < IN_DEPTH; i++) idle(1);

    // Flush with pending traffic on both sides, and an unmapped access.
    wb_wr(BASE, 32'h11);
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h22);
    step(1, 1, BASE + 32'h8, 32'h1, 1, 1, 8'h33);
    idle();
    wb_rd(BASE + 32'h4);
    step(1, 1, BASE + 32'hC, 32'h55, 0, 0, 8'h0);
    wb_rd(BASE + 32'h4);

`ifdef WB_NN_IRQ_EN
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h9);
    idle();
    check("irq_set", {31'h0, irq}, 32'h1);
    wb_rd(BASE);
    idle();
    check("irq_clr", {31'h0, irq}, 32'h0);
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'hA);
    wb_wr(BASE + 32'h8, 32'h4);
    idle();
    check("irq_mask", {31'h0, irq}, 32'h0);
    wb_wr(BASE + 32'h8, 32'h1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      op = $urandom_range(0, 19);
      if (op < 8)       step(0, 0, 32'h0, 32'h0, 1'($urandom), 1'($urandom), 8'($urandom));
      else if (op < 12) step(1, 1, BASE, $urandom, 1'($urandom), 1'($urandom), 8'($urandom));
      else if (op < 16) step(1, 0, BASE, 32'h0, 1'($urandom), 1'($urandom), 8'($urandom));
      else if (op < 18) step(1, 0, BASE + 32'h4, 32'h0, 1'($urandom), 1'($urandom), 8'($urandom));
      else if (op < 19) step(1, 1, BASE + 32'h8, 32'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 8'($urandom));
      else              step(1, $urandom_range(0, 1) == 1, BASE + 32'hC, $urandom, 1'($urandom), 0, 8'h0);
    end
    wb_wr(BASE + 32'h8, 32'h3);

    // Reset in the middle of an acked read with both FIFOs holding data.
    wb_wr(BASE, 32'h77);
    wb_wr(BASE, 32'h78);
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h5);
    step(0, 0, 32'h0, 32'h0, 0, 1, 8'h6);
    step(1, 0, BASE, 32'h0, 0, 0, 8'h0);
    rst = 1'b1;
    stb = 0; cyc = 0; nn_out_valid = 0;
    #1;
    check("mid_rst_ack", {31'h0, ack}, 32'h0);
    check("mid_rst_dat_o", dat_o, 32'h0);
    check("mid_rst_in_valid", {31'h0, nn_in_valid}, 32'h0);
    check("mid_rst_out_ready", {31'h0, nn_out_ready}, 32'h1);
    in_q.delete(); out_q.delete();
    m_ovf = 0; m_udf = 0; m_mask = 0; exp_ack = 0; exp_irq = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle();
    wb_rd(BASE + 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
